// File: rtl/cpu_pipe_pkg.sv
// Shared datapath definitions: payload widths and field layouts for each
// inter-stage boundary of the 5-stage pipeline.
package cpu_pipe_pkg;

  // IF/ID: fetched pc and instruction word
  localparam int IF_PC_LSB    = 0;
  localparam int IF_INSTR_LSB = 16;
  localparam int IF_ID_W      = 32;

  // ID/EX field offsets; must match the id_ex_t layout below
  localparam int IDX_REG_RD_1_LSB = 0;
  localparam int IDX_REG_RD_2_LSB = 16;
  localparam int IDX_PC_LSB       = 32;
  localparam int IDX_IMM_LSB      = 48;
  localparam int IDX_BR_OFF_LSB   = 64;
  localparam int IDX_RS_LSB       = 73;
  localparam int IDX_RT_LSB       = 77;
  localparam int IDX_RD_LSB       = 81;
  localparam int IDX_OP_LSB       = 85;
  localparam int IDX_CCODE_LSB    = 89;
  localparam int ID_EX_W          = 92;

  typedef struct packed {
    logic [2:0]  ccode;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rt;
    logic [3:0]  rs;
    logic [8:0]  br_off;
    logic [15:0] imm;
    logic [15:0] pc;
    logic [15:0] reg_rd_2;
    logic [15:0] reg_rd_1;
  } id_ex_t;

  // EX/MEM: alu result, store data, destination, opcode
  localparam int EXM_ALU_LSB  = 0;
  localparam int EXM_ST_LSB   = 16;
  localparam int EXM_RD_LSB   = 32;
  localparam int EXM_OP_LSB   = 36;
  localparam int EX_MEM_W     = 40;

  // MEM/WB: writeback data, destination, opcode
  localparam int MWB_DATA_LSB = 0;
  localparam int MWB_RD_LSB   = 16;
  localparam int MWB_OP_LSB   = 20;
  localparam int MEM_WB_W     = 24;

  typedef logic [1:0] occ_t;

  function automatic occ_t occ_count(input logic main_v, input logic skid_v);
    return occ_t'({1'b0, main_v}) + occ_t'({1'b0, skid_v});
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a 0..2 increment; sticks at all-ones, never wraps.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] cnt
);

  // One extra bit catches the carry out of the top, which means saturate.
  logic [CNT_W:0] sum;
  assign sum = {1'b0, cnt} + (CNT_W + 1)'(inc);

  always_ff @(posedge clk) begin
    if (!rst)
      cnt <= '0;
    else if (sum[CNT_W])
      cnt <= '1;
    else
      cnt <= sum[CNT_W-1:0];
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register: valid/ready handshake, optional 1-entry skid,
// hazard hold, branch flush and saturating stall/flush counters.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SKID   = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              m_v;
  logic [DATA_W-1:0] m_d;
  logic              s_v;
  logic              out_xfer;
  logic              in_xfer;

  assign out_xfer  = m_v & out_ready & ~hold;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = m_v;
  assign out_data  = m_d;
  assign occupancy = occ_count(m_v, s_v);

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] s_d;

      // Ready looks only at the skid flag, so out_ready never reaches in_ready.
      assign in_ready = ~s_v & ~flush;

      // NOTE: all state uses non-blocking (<=) so every register sees pre-edge values.
      always_ff @(posedge clk) begin
        if (!rst || flush) begin
          // NOTE: data registers are cleared too, so out_data reads 0 after reset/flush.
          m_v <= 1'b0;
          m_d <= '0;
          s_v <= 1'b0;
          s_d <= '0;
        end else if (out_xfer) begin
          if (s_v) begin
            m_d <= s_d;
            s_v <= 1'b0;
          end else begin
            m_v <= in_xfer;
            if (in_xfer) m_d <= in_data;
          end
        end else if (!m_v) begin
          if (in_xfer) begin
            m_v <= 1'b1;
            m_d <= in_data;
          end
        end else if (in_xfer) begin
          s_v <= 1'b1;
          s_d <= in_data;
        end
      end
    end else begin : g_noskid
      assign s_v      = 1'b0;
      assign in_ready = (~m_v | (out_ready & ~hold)) & ~flush;

      always_ff @(posedge clk) begin
        if (!rst || flush) begin
          m_v <= 1'b0;
          m_d <= '0;
        end else if (!m_v || out_xfer) begin
          m_v <= in_xfer;
          if (in_xfer) m_d <= in_data;
        end
      end
    end
  endgenerate

  logic [1:0] stall_inc;
  logic [1:0] flush_inc;

  assign stall_inc = {1'b0, ~flush & m_v & ~out_xfer};
  assign flush_inc = flush ? occupancy : 2'd0;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three configurations share one stimulus stream,
// each checked every cycle against a FIFO-level reference model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, flush, hold, in_valid, out_ready;
  logic [15:0] in_data;

  logic        ir  [3];
  logic        ov  [3];
  logic [15:0] od  [3];
  logic [1:0]  occ [3];
  logic [7:0]  sc0, sc1, fc0, fc1;
  logic [3:0]  sc2, fc2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // d0: SKID=1 CNT_W=8, d1: SKID=0 CNT_W=8, d2: SKID=1 CNT_W=4
  pipe_stage_reg #(.DATA_W(16), .SKID(1), .CNT_W(8)) u_d0 (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .occupancy(occ[0]), .stall_cnt(sc0), .flush_cnt(fc0));

  pipe_stage_reg #(.DATA_W(16), .SKID(0), .CNT_W(8)) u_d1 (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .occupancy(occ[1]), .stall_cnt(sc1), .flush_cnt(fc1));

  pipe_stage_reg #(.DATA_W(16), .SKID(1), .CNT_W(4)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .occupancy(occ[2]), .stall_cnt(sc2), .flush_cnt(fc2));

  // Reference model: a bounded FIFO of accepted payloads per instance.
  localparam bit SKID_M [3] = '{1'b1, 1'b0, 1'b1};
  localparam int CMAX   [3] = '{255, 255, 15};

  int          cnt_m [3];
  logic [15:0] ent   [3][2];
  logic [15:0] stale [3];
  int          scm   [3];
  int          fcm   [3];
  int          acc   [3];
  logic [15:0] last_acc [3];
  bit          probe = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic exp_ready(input int d);
    if (flush) return 1'b0;
    if (SKID_M[d]) return cnt_m[d] < 2;
    return (cnt_m[d] == 0) || (out_ready && !hold);
  endfunction

  function automatic logic [31:0] act_sc(input int d);
    case (d)
      0:       return 32'(sc0);
      1:       return 32'(sc1);
      default: return 32'(sc2);
    endcase
  endfunction

  function automatic logic [31:0] act_fc(input int d);
    case (d)
      0:       return 32'(fc0);
      1:       return 32'(fc1);
      default: return 32'(fc2);
    endcase
  endfunction

  function automatic logic [31:0] skid_without_main(input int d);
    case (d)
      0:       return 32'(u_d0.s_v & ~u_d0.m_v);
      1:       return 32'(u_d1.s_v & ~u_d1.m_v);
      default: return 32'(u_d2.s_v & ~u_d2.m_v);
    endcase
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_dut(input int d);
    string p;
    p = $sformatf("d%0d", d);
    check({p, "_in_ready"},  32'(ir[d]),  32'(exp_ready(d)));
    check({p, "_out_valid"}, 32'(ov[d]),  32'(cnt_m[d] > 0));
    check({p, "_out_data"},  32'(od[d]),  32'((cnt_m[d] > 0) ? ent[d][0] : stale[d]));
    check({p, "_occupancy"}, 32'(occ[d]), 32'(cnt_m[d]));
    check({p, "_stall_cnt"}, act_sc(d),   32'(scm[d]));
    check({p, "_flush_cnt"}, act_fc(d),   32'(fcm[d]));
    check({p, "_invariant"}, skid_without_main(d), 32'(0));
  endtask

  task automatic model_step(input int d);
    bit ox, ix;
    if (!rst) begin
      cnt_m[d] = 0; stale[d] = '0; scm[d] = 0; fcm[d] = 0;
    end else if (flush) begin
      fcm[d]   = sat(fcm[d] + cnt_m[d], CMAX[d]);
      cnt_m[d] = 0;
      stale[d] = '0;
    end else begin
      ox = (cnt_m[d] > 0) && out_ready && !hold;
      ix = in_valid && exp_ready(d);
      if (cnt_m[d] > 0 && !ox) scm[d] = sat(scm[d] + 1, CMAX[d]);
      if (ox) begin
        stale[d]  = ent[d][0];
        ent[d][0] = ent[d][1];
        cnt_m[d]--;
      end
      if (ix) begin
        ent[d][cnt_m[d]] = in_data;
        cnt_m[d]++;
        acc[d]++;
        last_acc[d] = in_data;
      end
    end
  endtask

  // Check at the falling edge with inputs stable, then advance to just past the rising edge.
  task automatic cycle();
    logic ir_before;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check_dut(d);
    if (probe) begin
      ir_before = ir[0];
      out_ready = ~out_ready;
      #1;
      check("d0_in_ready_vs_out_ready", 32'(ir[0]), 32'(ir_before));
      out_ready = ~out_ready;
      #1;
    end
    for (int d = 0; d < 3; d++) model_step(d);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [15:0] dat, input bit ordy,
                       input bit hld, input bit fl);
    in_valid  = v;
    in_data   = dat;
    out_ready = ordy;
    hold      = hld;
    flush     = fl;
  endtask

  task automatic do_reset();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      cnt_m[d] = 0; stale[d] = '0; scm[d] = 0; fcm[d] = 0; acc[d] = 0;
      last_acc[d] = '0; ent[d][0] = '0; ent[d][1] = '0;
    end
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

    // Reset then back-to-back stream
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(i), 1'b1, 1'b0, 1'b0);
      cycle();
      check("t1_d0_occ_le_1", 32'(occ[0] <= 2'd1), 32'(1));
      check("t1_d0_out_data", 32'(od[0]), 32'(i));
    end
    drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle();

    // Hold fills the skid, then drains in order
    do_reset();
    drive(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 16'hBBBB, 1'b1, 1'b1, 1'b0); cycle();
    check("t2_d0_in_ready_full", 32'(ir[0]), 32'(0));
    check("t2_d0_occ_full", 32'(occ[0]), 32'(2));
    drive(1'b1, 16'hCCCC, 1'b1, 1'b1, 1'b0); cycle();
    drive(1'b0, 16'h0,    1'b1, 1'b1, 1'b0); cycle();
    check("t2_d0_stall_cnt", act_sc(0), 32'(3));
    for (int i = 0; i < 10 && last_acc[0] != 16'hCCCC; i++) begin
      drive(1'b1, 16'hCCCC, 1'b1, 1'b0, 1'b0);
      cycle();
    end
    check("t2_d0_cccc_accepted", 32'(last_acc[0]), 32'hCCCC);
    drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    repeat (4) cycle();

    // Flush a full stage with a payload on the input
    do_reset();
    drive(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1); cycle();
    drive(1'b0, 16'h0,    1'b1, 1'b0, 1'b0);
    check("t3_d0_out_valid", 32'(ov[0]),  32'(0));
    check("t3_d0_out_data",  32'(od[0]),  32'(0));
    check("t3_d0_occ",       32'(occ[0]), 32'(0));
    check("t3_d0_flush_cnt", act_fc(0),   32'(2));
    check("t3_d1_flush_cnt", act_fc(1),   32'(1));
    repeat (3) cycle();

    // Stall counter saturation on the 4-bit instance
    do_reset();
    drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    repeat (20) cycle();
    check("t5_d2_stall_sat", act_sc(2), 32'(15));
    check("t5_d0_stall_20",  act_sc(0), 32'(20));
    repeat (3) cycle();
    check("t5_d2_stall_stays", act_sc(2), 32'(15));

    // Reset in the middle of operation
    do_reset();
    drive(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 16'hBBBB, 1'b1, 1'b1, 1'b0); cycle();
    drive(1'b0, 16'h0,    1'b1, 1'b1, 1'b0);
    repeat (4) cycle();
    check("t6_d0_occ_before", 32'(occ[0]), 32'(2));
    check("t6_d0_stall_before", act_sc(0), 32'(5));
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    check("t6_d0_out_valid", 32'(ov[0]),  32'(0));
    check("t6_d0_out_data",  32'(od[0]),  32'(0));
    check("t6_d0_occ",       32'(occ[0]), 32'(0));
    check("t6_d0_in_ready",  32'(ir[0]),  32'(1));
    check("t6_d0_stall_cnt", act_sc(0),   32'(0));

    // Randomised traffic with backpressure, hold and occasional flush
    do_reset();
    for (int d = 0; d < 3; d++) acc[d] = 0;
    begin
      int i;
      for (i = 0; i < 30000 && (acc[0] < 1000 || acc[1] < 1000); i++) begin
        probe = (i % 7 == 3);
        drive($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 6,
              $urandom_range(0, 9) < 2, $urandom_range(0, 63) == 0);
        cycle();
      end
      probe = 1'b0;
      check("t4_cycle_budget", 32'(i < 30000), 32'(1));
    end
    drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    repeat (4) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
